fp32_invsqrt_seq: RTL and testbench

- Multi-cycle sequencer that computes fp32 1/sqrt(x) by Newton-Raphson.
- Initial guess is the magic-constant estimate, refined by y(n+1) = y(n) * (1.5 - (x/2) * y(n)^2).
- The block owns no arithmetic. It schedules operations onto one shared external fp32 multiplier and one fp32 adder through request/result ports, which removes the long combinational chain of a flat N-R datapath.
- Special operands are resolved locally without using the shared units.

---
 rtl/fp32_invsqrt_seq.sv | 188 ++++++++++++++++++
 tb/tb_fp32_invsqrt_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_invsqrt_seq.sv
// fp32 1/sqrt(x): magic-constant seed refined by Newton-Raphson passes, with every
// multiply and add issued to one shared external fp32 multiplier and one fp32 adder.
module fp32_invsqrt_seq #(
    parameter int          ITERATIONS = 2,
    parameter logic [31:0] MAGIC      = 32'h5f3759df
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        mul_req_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_res_valid,
    input  logic [31:0] mul_res,
    output logic        add_req_valid,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic        add_res_valid,
    input  logic [31:0] add_res
);
    localparam logic [31:0] FP_HALF   = 32'h3F000000;
    localparam logic [31:0] FP_1P5    = 32'h3FC00000;
    localparam logic [31:0] RES_NAN   = 32'h7FC00001;
    localparam logic [31:0] RES_PINF  = 32'h7F800000;
    localparam logic [2:0]  LAST_ITER = 3'(ITERATIONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALF,
        S_SQ,
        S_TERM,
        S_SUB,
        S_UPD,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_first;
    logic [31:0] r_x;
    logic [31:0] r_x_half;
    logic [31:0] r_y;
    logic [31:0] r_t;
    logic [31:0] r_out_data;
    logic [2:0]  r_iter;

    logic        w_is_special;
    logic [31:0] w_special_res;
    logic        w_mul_done;
    logic        w_add_done;
    logic        w_enter_op;

    always_comb begin
        w_is_special  = 1'b1;
        w_special_res = RES_NAN;
        if (in_data[30:23] == 8'hFF && in_data[22:0] != 23'd0) begin
            w_special_res = RES_NAN;
        end else if (in_data[31] && in_data[30:0] != 31'd0) begin
            w_special_res = RES_NAN;
        end else if (in_data[30:0] == 31'h7F800000) begin
            w_special_res = 32'h00000000;
        end else if (in_data[30:0] == 31'd0) begin
            w_special_res = RES_PINF;
        end else begin
            w_is_special = 1'b0;
        end
    end

    // A result in the request cycle cannot belong to that request (latency >= 1),
    // so it is a leftover and is dropped.
    assign w_mul_done = mul_res_valid & ~r_first;
    assign w_add_done = add_res_valid & ~r_first;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_next = w_is_special ? S_DONE : S_HALF;
            S_HALF: if (w_mul_done) w_state_next = S_SQ;
            S_SQ:   if (w_mul_done) w_state_next = S_TERM;
            S_TERM: if (w_mul_done) w_state_next = S_SUB;
            S_SUB:  if (w_add_done) w_state_next = S_UPD;
            S_UPD:  if (w_mul_done) w_state_next = (r_iter == LAST_ITER) ? S_DONE : S_SQ;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_enter_op = (w_state_next != r_state) &&
                        (w_state_next != S_IDLE) && (w_state_next != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_first <= w_enter_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= 32'd0;
            r_x_half   <= 32'd0;
            r_y        <= 32'd0;
            r_t        <= 32'd0;
            r_out_data <= 32'd0;
            r_iter     <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x <= in_data;
                        if (w_is_special) begin
                            r_out_data <= w_special_res;
                        end else begin
                            r_y    <= MAGIC - (in_data >> 1);
                            r_iter <= 3'd0;
                        end
                    end
                end
                S_HALF: if (w_mul_done) r_x_half <= mul_res;
                S_SQ:   if (w_mul_done) r_t <= mul_res;
                S_TERM: if (w_mul_done) r_t <= mul_res;
                S_SUB:  if (w_add_done) r_t <= add_res;
                S_UPD: begin
                    if (w_mul_done) begin
                        r_y    <= mul_res;
                        r_iter <= r_iter + 3'd1;
                        if (r_iter == LAST_ITER) r_out_data <= mul_res;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operands come straight from registers that only change on the capture edge,
    // so they stay stable for the whole wait.
    always_comb begin
        mul_req_valid = 1'b0;
        mul_a         = 32'd0;
        mul_b         = 32'd0;
        add_req_valid = 1'b0;
        add_a         = 32'd0;
        add_b         = 32'd0;
        case (r_state)
            S_HALF: begin
                mul_req_valid = r_first;
                mul_a         = r_x;
                mul_b         = FP_HALF;
            end
            S_SQ: begin
                mul_req_valid = r_first;
                mul_a         = r_y;
                mul_b         = r_y;
            end
            S_TERM: begin
                mul_req_valid = r_first;
                mul_a         = r_x_half;
                mul_b         = r_t;
            end
            S_SUB: begin
                add_req_valid = r_first;
                add_a         = FP_1P5;
                add_b         = {~r_t[31], r_t[30:0]};
            end
            S_UPD: begin
                mul_req_valid = r_first;
                mul_a         = r_y;
                mul_b         = r_t;
            end
            default: ;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_fp32_invsqrt_seq.sv
// Bench for fp32_invsqrt_seq: two instances (2 and 1 passes) backed by behavioural
// fp32 units, checked every cycle against a transaction-level 1/sqrt model.
module tb_fp32_invsqrt_seq;
    localparam int N = 2;
    localparam logic [31:0] MAGIC = 32'h5f3759df;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid [N];
    logic        in_ready [N];
    logic [31:0] in_data [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [31:0] out_data [N];
    logic        busy [N];
    logic        mul_req_valid [N];
    logic [31:0] mul_a [N];
    logic [31:0] mul_b [N];
    logic        mul_res_valid [N];
    logic [31:0] mul_res [N];
    logic        add_req_valid [N];
    logic [31:0] add_a [N];
    logic [31:0] add_b [N];
    logic        add_res_valid [N];
    logic [31:0] add_res [N];

    int n_cmp = 0;
    int n_fail = 0;
    int lat_m = 1;
    int lat_a = 1;
    bit rand_lat = 1'b0;

    logic [63:0] exp_mul_q [N][$];
    logic [63:0] exp_add_q [N][$];
    logic [31:0] exp_out [N];
    int          n_mul_seen [N] = '{0, 0};
    int          n_add_seen [N] = '{0, 0};
    logic        prev_m [N] = '{1'b0, 1'b0};
    logic        prev_a [N] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        real r;
        if (f[30:23] == 8'd0) begin
            r = real'(f[22:0]) * $bitstoreal({1'b0, 11'd874, 52'd0});
            return f[31] ? -r : r;
        end
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] m;
        logic        up;
        int          e;
        if (r == 0.0) return 32'h0;
        d  = $realtobits(r);
        e  = int'(d[62:52]) - 896;
        up = d[28] & ((|d[27:0]) | d[29]);
        m  = {2'b01, d[51:29]} + {24'd0, up};
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e <= 0) return {d[63], 31'h0};
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic int iters_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic chk_rel(input string name, input logic [31:0] got, input real want, input real tol);
        real err;
        n_cmp++;
        err = f2r(got) / want - 1.0;
        if (err < 0.0) err = -err;
        if (!(err <= tol)) begin
            n_fail++;
            $display("FAIL %s: got %h (%g) required within rel %g of %g", name, got, f2r(got), tol, want);
        end
    endtask

    // Expected result and the exact op stream the sequencer must issue for x.
    task automatic expect_op(input int i, input logic [31:0] x);
        logic [31:0] y, xh, t, nb, s;
        exp_mul_q[i].delete();
        exp_add_q[i].delete();
        if (x[30:23] == 8'hFF && x[22:0] != 0) begin exp_out[i] = 32'h7FC00001; return; end
        if (x[31] && x[30:0] != 0)             begin exp_out[i] = 32'h7FC00001; return; end
        if (x == 32'h7F800000)                 begin exp_out[i] = 32'h00000000; return; end
        if (x[30:0] == 0)                      begin exp_out[i] = 32'h7F800000; return; end
        y  = MAGIC - (x >> 1);
        exp_mul_q[i].push_back({x, 32'h3F000000});
        xh = fmul(x, 32'h3F000000);
        for (int k = 0; k < iters_of(i); k++) begin
            exp_mul_q[i].push_back({y, y});
            t = fmul(y, y);
            exp_mul_q[i].push_back({xh, t});
            t = fmul(xh, t);
            nb = t ^ 32'h80000000;
            exp_add_q[i].push_back({32'h3FC00000, nb});
            s = fadd(32'h3FC00000, nb);
            exp_mul_q[i].push_back({y, s});
            y = fmul(y, s);
        end
        exp_out[i] = y;
    endtask

    for (genvar gi = 0; gi < N; gi++) begin : g_inst
        localparam int IT = (gi == 0) ? 2 : 1;

        fp32_invsqrt_seq #(.ITERATIONS(IT), .MAGIC(MAGIC)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid[gi]), .in_ready(in_ready[gi]), .in_data(in_data[gi]),
            .out_valid(out_valid[gi]), .out_ready(out_ready[gi]), .out_data(out_data[gi]),
            .busy(busy[gi]),
            .mul_req_valid(mul_req_valid[gi]), .mul_a(mul_a[gi]), .mul_b(mul_b[gi]),
            .mul_res_valid(mul_res_valid[gi]), .mul_res(mul_res[gi]),
            .add_req_valid(add_req_valid[gi]), .add_a(add_a[gi]), .add_b(add_b[gi]),
            .add_res_valid(add_res_valid[gi]), .add_res(add_res[gi])
        );

        // External units: not reset with the DUT, so in-flight results still land.
        int          m_cnt = 0;
        int          a_cnt = 0;
        logic        m_busy = 1'b0;
        logic        a_busy = 1'b0;
        logic [31:0] m_val = 32'd0;
        logic [31:0] a_val = 32'd0;

        assign mul_res_valid[gi] = m_busy && (m_cnt == 1);
        assign mul_res[gi]       = (m_busy && m_cnt == 1) ? m_val : 32'hDEADBEEF;
        assign add_res_valid[gi] = a_busy && (a_cnt == 1);
        assign add_res[gi]       = (a_busy && a_cnt == 1) ? a_val : 32'hDEADBEEF;

        always @(posedge clk) begin
            if (mul_req_valid[gi]) begin
                m_busy <= 1'b1;
                m_val  <= fmul(mul_a[gi], mul_b[gi]);
                m_cnt  <= rand_lat ? int'($urandom_range(8, 1)) : lat_m;
            end else if (m_busy) begin
                if (m_cnt == 1) m_busy <= 1'b0;
                else m_cnt <= m_cnt - 1;
            end
            if (add_req_valid[gi]) begin
                a_busy <= 1'b1;
                a_val  <= fadd(add_a[gi], add_b[gi]);
                a_cnt  <= rand_lat ? int'($urandom_range(8, 1)) : lat_a;
            end else if (a_busy) begin
                if (a_cnt == 1) a_busy <= 1'b0;
                else a_cnt <= a_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                prev_m[i] <= 1'b0;
                prev_a[i] <= 1'b0;
            end else begin
                chk("in_ready_vs_busy", in_ready[i], !busy[i]);
                if (mul_req_valid[i]) begin
                    n_mul_seen[i] <= n_mul_seen[i] + 1;
                    chk("mul_pulse_width", prev_m[i], 1'b0);
                    chk("mul_req_expected", exp_mul_q[i].size() != 0, 1'b1);
                    if (exp_mul_q[i].size() != 0) chk("mul_operands", {mul_a[i], mul_b[i]}, exp_mul_q[i].pop_front());
                end
                if (add_req_valid[i]) begin
                    n_add_seen[i] <= n_add_seen[i] + 1;
                    chk("add_pulse_width", prev_a[i], 1'b0);
                    chk("add_req_expected", exp_add_q[i].size() != 0, 1'b1);
                    if (exp_add_q[i].size() != 0) chk("add_operands", {add_a[i], add_b[i]}, exp_add_q[i].pop_front());
                end
                if (out_valid[i]) begin
                    chk("out_data", out_data[i], exp_out[i]);
                    chk("in_ready_in_done", in_ready[i], 1'b0);
                end
                prev_m[i] <= mul_req_valid[i];
                prev_a[i] <= add_req_valid[i];
            end
        end
    end

    task automatic chk_reset(input int i);
        chk("rst_in_ready", in_ready[i], 1'b1);
        chk("rst_busy", busy[i], 1'b0);
        chk("rst_out_valid", out_valid[i], 1'b0);
        chk("rst_out_data", out_data[i], 32'd0);
        chk("rst_req", {mul_req_valid[i], add_req_valid[i]}, 2'b00);
        chk("rst_mul_ops", {mul_a[i], mul_b[i]}, 64'd0);
        chk("rst_add_ops", {add_a[i], add_b[i]}, 64'd0);
    endtask

    task automatic run_op(input int i, input logic [31:0] x, input int exp_lat, input int exp_nm,
                          input int exp_na, input int bp, output logic [31:0] res);
        int lat, nm0, na0;
        expect_op(i, x);
        nm0 = n_mul_seen[i];
        na0 = n_add_seen[i];
        res = 32'hX;
        out_ready[i] = (bp == 0);
        for (int c = 0; c < 100 && !in_ready[i]; c++) @(negedge clk);
        chk("accept_ready", in_ready[i], 1'b1);
        in_valid[i] = 1'b1;
        in_data[i]  = x;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        in_data[i]  = 32'h12345678;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[i] && lat < 3000);
        if (!out_valid[i]) begin
            chk("out_valid_timeout", out_valid[i], 1'b1);
            out_ready[i] = 1'b1;
            return;
        end
        res = out_data[i];
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid[i], 1'b1);
            chk("bp_in_ready", in_ready[i], 1'b0);
        end
        out_ready[i] = 1'b1;
        @(negedge clk);
        chk("post_hs_in_ready", in_ready[i], 1'b1);
        chk("post_hs_out_valid", out_valid[i], 1'b0);
        if (exp_nm >= 0) chk("mul_count", n_mul_seen[i] - nm0, exp_nm);
        if (exp_na >= 0) chk("add_count", n_add_seen[i] - na0, exp_na);
        chk("ops_drained", exp_mul_q[i].size() + exp_add_q[i].size(), 0);
        $display("txn inst=%0d x=%h out=%h lat=%0d muls=%0d adds=%0d", i, x, res, lat,
                 n_mul_seen[i] - nm0, n_add_seen[i] - na0);
    endtask

    logic [31:0] sp_x [6] = '{32'h7F800000, 32'h00000000, 32'h80000000,
                              32'h7FC00000, 32'hBF800000, 32'hFF800000};
    logic [31:0] sp_r [6] = '{32'h00000000, 32'h7F800000, 32'h7F800000,
                              32'h7FC00001, 32'h7FC00001, 32'h7FC00001};

    initial begin
        logic [31:0] res;
        int cnt;
        for (int i = 0; i < N; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = 32'd0;
            out_ready[i] = 1'b1;
            exp_out[i]   = 32'd0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-derived anchors for the model: 4.0 seeds y0 = 5f3759df - 20400000.
        expect_op(0, 32'h40800000);
        chk("model_mul0", exp_mul_q[0][0], {32'h40800000, 32'h3F000000});
        chk("model_mul1", exp_mul_q[0][1], {32'h3EF759DF, 32'h3EF759DF});
        chk_rel("model_4p0", exp_out[0], 0.5, 1.0e-5);
        exp_mul_q[0].delete();
        exp_add_q[0].delete();

        run_op(0, 32'h40800000, 19, 7, 2, 0, res);
        chk_rel("dut_4p0", res, 0.5, 1.0e-5);

        for (int k = 0; k < 6; k++) begin
            run_op(0, sp_x[k], 1, 0, 0, 0, res);
            chk("special_result", res, sp_r[k]);
        end

        run_op(0, 32'h40800000, 19, 7, 2, 10, res);

        rand_lat = 1'b1;
        run_op(0, 32'h42C80000, -1, 7, 2, 0, res);
        chk_rel("dut_100", res, 0.1, 1.0e-5);
        rand_lat = 1'b0;

        // Reset while the TERM multiply is outstanding on a slow multiplier.
        lat_m = 5;
        expect_op(0, 32'h40800000);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h40800000;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 500 && cnt < 3; c++) begin
            @(negedge clk);
            if (mul_req_valid[0]) cnt++;
        end
        chk("term_reached", cnt, 3);
        @(negedge clk);
        rst_n = 1'b0;
        exp_mul_q[0].delete();
        exp_add_q[0].delete();
        #1 chk_reset(0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("stale_ignored_idle", {in_ready[0], busy[0], out_valid[0]}, 3'b100);
        $display("txn inst=0 reset during TERM, stale multiply result discarded");
        lat_m = 1;
        run_op(0, 32'h3F800000, 19, 7, 2, 0, res);
        chk_rel("dut_1p0", res, 1.0, 1.0e-5);

        run_op(1, 32'h40800000, 11, 4, 1, 0, res);
        chk_rel("dut_it1_4p0", res, 0.5, 2.0e-3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
